// File: rtl/demux_1to8_sched_pkg.sv
// Shared types and helpers for the 1-to-8 demux scheduler.
// Provides the FSM state, the channel geometry and the circular priority pick.
package demux_sched_pkg;

   localparam int unsigned NUM_CH = 8;
   localparam int unsigned SEL_W  = 3;

   typedef enum logic {IDLE, XFER} state_t;

   typedef struct packed {
      logic             vld;
      logic [SEL_W-1:0] idx;
   } pick_t;

   // First requesting channel strictly after ptr, wrapping 7 -> 0.
   function automatic pick_t next_rr(input logic [SEL_W-1:0] ptr, input logic [NUM_CH-1:0] req);
      pick_t            p;
      logic [SEL_W-1:0] c;
      p = '0;
      for (int unsigned i = 1; i <= NUM_CH; i++) begin
         c = SEL_W'(ptr + i);
         if (!p.vld && req[c]) begin
            p.vld = 1'b1;
            p.idx = c;
         end
      end
      return p;
   endfunction

endpackage

// File: rtl/demux_1to8_sched_if.sv
// Stream-in / demux-out bundle of the scheduler.
// master = upstream source and channel sinks, slave = the scheduler itself.
interface demux_1to8_sched_if #(
   parameter int unsigned DATA_WIDTH = 8
);
   import demux_sched_pkg::*;

   logic                  i_valid;
   logic                  o_ready;
   logic [DATA_WIDTH-1:0] i_data;
   logic                  i_last;
   logic                  i_mode;
   logic [SEL_W-1:0]      i_dest;
   logic [NUM_CH-1:0]     i_ch_mask;
   logic [NUM_CH-1:0]     i_ch_ready;
   logic                  o_en;
   logic [SEL_W-1:0]      o_sel;
   logic [DATA_WIDTH-1:0] o_data;
   logic                  o_busy;
   logic                  o_timeout;

   modport master (
      output i_valid, i_data, i_last, i_mode, i_dest, i_ch_mask, i_ch_ready,
      input  o_ready, o_en, o_sel, o_data, o_busy, o_timeout
   );

   modport slave (
      input  i_valid, i_data, i_last, i_mode, i_dest, i_ch_mask, i_ch_ready,
      output o_ready, o_en, o_sel, o_data, o_busy, o_timeout
   );

endinterface

// File: rtl/demux_1to8_sched_arb.sv
// Combinational masked round-robin pick over the eight demux channels.
module rr_arbiter_8
   import demux_sched_pkg::*;
(
   input  logic [NUM_CH-1:0] req,
   input  logic [SEL_W-1:0]  ptr,
   output logic [SEL_W-1:0]  gnt_idx,
   output logic              gnt_vld
);

   pick_t pick;

   assign pick    = next_rr(ptr, req);
   assign gnt_idx = pick.idx;
   assign gnt_vld = pick.vld;

endmodule

// File: rtl/demux_1to8_sched.sv
// Burst scheduler feeding the 1-to-8 demux: arbitrates a channel, then moves
// up to BURST_LEN beats to it with registered enable/select/data.
module demux_1to8_sched
   import demux_sched_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned BURST_LEN  = 4,
   parameter int unsigned STALL_MAX  = 64
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   demux_1to8_sched_if.slave  bus
);

   localparam int unsigned        CNT_W      = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam int unsigned        STALL_W    = (STALL_MAX > 1) ? $clog2(STALL_MAX) : 1;
   localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(BURST_LEN - 1);
   localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'((STALL_MAX > 0) ? STALL_MAX - 1 : 0);
   localparam bit                 WD_EN      = (STALL_MAX != 0);

   state_t                state_q, state_d;
   logic [SEL_W-1:0]      sel_q, sel_d;
   logic [SEL_W-1:0]      ptr_q, ptr_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [STALL_W-1:0]    stall_q, stall_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  en_q, en_d;
   logic                  to_q, to_d;

   logic [NUM_CH-1:0]     elig;
   logic [SEL_W-1:0]      rr_idx, grant_idx;
   logic                  rr_vld, grant_vld;
   logic                  ready, accept;

   assign elig = bus.i_ch_mask & bus.i_ch_ready;

   rr_arbiter_8 u_arb (
      .req     (elig),
      .ptr     (ptr_q),
      .gnt_idx (rr_idx),
      .gnt_vld (rr_vld)
   );

   // Mode, destination and mask only matter here, i.e. in IDLE.
   assign grant_idx = bus.i_mode ? bus.i_dest       : rr_idx;
   assign grant_vld = bus.i_mode ? elig[bus.i_dest] : rr_vld;

   assign ready  = (state_q == XFER) && bus.i_ch_ready[sel_q];
   assign accept = ready && bus.i_valid;

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      stall_d = stall_q;
      data_d  = data_q;
      en_d    = 1'b0;
      to_d    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.i_valid && grant_vld) begin
               state_d = XFER;
               sel_d   = grant_idx;
               ptr_d   = grant_idx;
               cnt_d   = '0;
               stall_d = '0;
            end
         end
         XFER: begin
            if (accept) begin
               data_d  = bus.i_data;
               en_d    = 1'b1;
               cnt_d   = cnt_q + 1'b1;
               stall_d = '0;
               if (bus.i_last || cnt_q == CNT_LAST) state_d = IDLE;
            end else if (WD_EN && stall_q == STALL_LAST) begin
               // Abort keeps ptr on the stalled channel so it loses priority next time.
               state_d = IDLE;
               to_d    = 1'b1;
               stall_d = '0;
            end else begin
               stall_d = stall_q + 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= IDLE;
         sel_q   <= '0;
         ptr_q   <= '1;
         cnt_q   <= '0;
         stall_q <= '0;
         data_q  <= '0;
         en_q    <= 1'b0;
         to_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         stall_q <= stall_d;
         data_q  <= data_d;
         en_q    <= en_d;
         to_q    <= to_d;
      end
   end

   assign bus.o_ready   = ready;
   assign bus.o_en      = en_q;
   assign bus.o_sel     = sel_q;
   assign bus.o_data    = data_q;
   assign bus.o_busy    = (state_q == XFER);
   assign bus.o_timeout = to_q;

endmodule
